// File: rtl/execute_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : execute_muldiv_unit                                          |
// | Description : Iterative EX-stage multiply/divide unit owning HI/LO.        |
// |               Shift-add multiply and restoring divide, one bit per cycle,  |
// |               with a sign-correction cycle before HI/LO commit.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module execute_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      ex_muldiv_op,
  input  logic [XLEN-1:0] ex_reg1_data,
  input  logic [XLEN-1:0] ex_reg2_data,
  input  logic            ex_hold,
  output logic            ex_stall,
  output logic [XLEN-1:0] ex_hi,
  output logic [XLEN-1:0] ex_lo,
  output logic            ex_busy
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [ITER_W-1:0] c_last_iter = ITER_W'(XLEN - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [ITER_W-1:0] r_cnt;
  // Multiply: {partial product, remaining multiplier}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;     // multiplicand magnitude or divisor magnitude
  logic              r_is_div;
  logic              r_neg_lo;   // negate product / quotient
  logic              r_neg_hi;   // remainder follows dividend sign

  // Operation decode and operand magnitudes for the capture edge
  logic              w_is_md;
  logic              w_op_signed;
  logic              w_op_div;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;

  assign w_is_md     = (ex_muldiv_op >= c_op_mult) && (ex_muldiv_op <= c_op_divu);
  assign w_op_signed = (ex_muldiv_op == c_op_mult) || (ex_muldiv_op == c_op_div);
  assign w_op_div    = (ex_muldiv_op == c_op_div)  || (ex_muldiv_op == c_op_divu);
  assign w_sign_a    = w_op_signed & ex_reg1_data[XLEN-1];
  assign w_sign_b    = w_op_signed & ex_reg2_data[XLEN-1];
  assign w_mag_a     = w_sign_a ? -ex_reg1_data : ex_reg1_data;
  assign w_mag_b     = w_sign_b ? -ex_reg2_data : ex_reg2_data;

  // One shift-add multiply step: add multiplicand if LSB set, then shift right
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring divide step; a zero divisor always "fits", giving all-ones quotient
  logic [XLEN:0]     w_div_shift;
  logic              w_div_fits;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_next;

  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_fits  = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_opnd;
  assign w_div_next  = {(w_div_fits ? w_div_sub : w_div_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_fits};

  // Sign correction applied during the FIX cycle
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  assign w_prod   = r_neg_lo ? -r_acc : r_acc;
  assign w_rem    = r_neg_hi ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_res_hi = r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
  assign w_res_lo = w_prod[XLEN-1:0];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_is_md) w_next_state = c_st_run;
      c_st_run:  if (r_cnt == c_last_iter) w_next_state = c_st_fix;
      c_st_fix:  w_next_state = c_st_done;
      c_st_done: if (!ex_hold) w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Outputs: stall covers the issue cycle in IDLE plus RUN and FIX
  always_comb begin
    ex_stall = 1'b0;
    ex_busy  = 1'b0;
    case (r_state)
      c_st_idle: ex_stall = w_is_md;
      c_st_run,
      c_st_fix: begin
        ex_stall = 1'b1;
        ex_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO commit and MTHI/MTLO writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_is_md) begin
            r_acc    <= {{XLEN{1'b0}}, w_mag_a};
            r_opnd   <= w_mag_b;
            r_cnt    <= '0;
            r_is_div <= w_op_div;
            // Divide by zero keeps the raw all-ones quotient
            r_neg_lo <= (w_sign_a ^ w_sign_b) & ~(w_op_div & (ex_reg2_data == '0));
            r_neg_hi <= w_sign_a;
          end else if (ex_muldiv_op == c_op_mthi) begin
            r_hi <= ex_reg1_data;
          end else if (ex_muldiv_op == c_op_mtlo) begin
            r_lo <= ex_reg1_data;
          end
        end
        c_st_run: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + ITER_W'(1);
        end
        c_st_fix: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign ex_hi = r_hi;
  assign ex_lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_execute_muldiv_unit                                       |
// | Description : Scoreboard bench for execute_muldiv_unit with an arithmetic  |
// |               reference model and randomized operations.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_execute_muldiv_unit;

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      ex_muldiv_op;
  logic [XLEN-1:0] ex_reg1_data;
  logic [XLEN-1:0] ex_reg2_data;
  logic            ex_hold;
  logic            ex_stall;
  logic [XLEN-1:0] ex_hi;
  logic [XLEN-1:0] ex_lo;
  logic            ex_busy;

  execute_muldiv_unit #(.XLEN(XLEN), .ITER_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_muldiv_op (ex_muldiv_op),
    .ex_reg1_data (ex_reg1_data),
    .ex_reg2_data (ex_reg2_data),
    .ex_hold      (ex_hold),
    .ex_stall     (ex_stall),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_busy      (ex_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          md;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural HI/LO after an operation, from plain arithmetic
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              sa;
    int              sb;
    case (op)
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: begin
        pu = {32'b0, a} * {32'b0, b};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      3'd3: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else begin
          sa = a;
          sb = b;
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
      end
      3'd4: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Driver: called at posedge+1; returns at posedge+1 with the op retired
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    exp_t e;
    int   n;
    ex_muldiv_op = op;
    ex_reg1_data = a;
    ex_reg2_data = b;
    model_apply(op, a, b);
    e.md = (op >= 3'd1 && op <= 3'd4);
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);
    if (e.md) begin
      ex_hold = (hold > 0);
      n = 0;
      do begin
        @(posedge clock); #1;
        ex_reg1_data = $urandom;
        ex_reg2_data = $urandom;
        n++;
      end while (ex_stall && n < 100);
      check("stall_timeout", {31'b0, ex_stall}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        check("hold_no_restart", {31'b0, ex_stall}, 32'd0);
      end
      ex_hold = 1'b0;
      @(posedge clock); #1;
      // Back in IDLE, the still-visible mul/div op raises the issue stall
      check("idle_after_done", {31'b0, ex_stall}, 32'd1);
      ex_muldiv_op = 3'd0;
    end else begin
      @(posedge clock); #1;
      ex_muldiv_op = 3'd0;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ex_muldiv_op = 3'd0;
    #1;
    check("rst_stall", {31'b0, ex_stall}, 32'd0);
    check("rst_busy", {31'b0, ex_busy}, 32'd0);
    check("rst_hi", ex_hi, 32'd0);
    check("rst_lo", ex_lo, 32'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Monitor: pops expected state when the DUT presents a result
  initial begin : monitor
    exp_t e;
    bit   prev_stall = 1'b0;
    bit   pend_mt    = 1'b0;
    int   run_len    = 0;
    int   busy_len   = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
        pend_mt    = 1'b0;
        run_len    = 0;
        busy_len   = 0;
      end else begin
        if (pend_mt) begin
          pend_mt = 1'b0;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL mt_queue: got empty expected entry");
          end else begin
            e = sb_q.pop_front();
            check("mt_kind", {31'b0, e.md}, 32'd0);
            check("mt_hi", ex_hi, e.hi);
            check("mt_lo", ex_lo, e.lo);
          end
        end
        if (ex_stall) begin
          run_len++;
          if (ex_busy) busy_len++;
        end else if (prev_stall) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL md_queue: got empty expected entry");
          end else begin
            e = sb_q.pop_front();
            check("md_kind", {31'b0, e.md}, 32'd1);
            check("stall_len", run_len, 32'd34);
            check("busy_len", busy_len, 32'd33);
            check("done_busy", {31'b0, ex_busy}, 32'd0);
            check("md_hi", ex_hi, e.hi);
            check("md_lo", ex_lo, e.lo);
          end
          run_len  = 0;
          busy_len = 0;
        end
        if (!ex_stall && (ex_muldiv_op == 3'd5 || ex_muldiv_op == 3'd6)) pend_mt = 1'b1;
        prev_stall = ex_stall;
      end
    end
  end

  initial begin : stimulus
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    reset        = 1'b1;
    ex_muldiv_op = 3'd0;
    ex_reg1_data = '0;
    ex_reg2_data = '0;
    ex_hold      = 1'b0;
    @(posedge clock); #1;
    do_reset();

    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    issue(3'd4, 32'd100, 32'd7, 0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd4, 32'h0000_1234, 32'd0, 0);
    issue(3'd3, 32'hFFFF_FFF0, 32'd0, 0);
    issue(3'd5, 32'hCAFE_BABE, 32'd0, 0);
    issue(3'd6, 32'h0BAD_F00D, 32'd0, 0);
    issue(3'd1, 32'h0001_2345, 32'hFFFF_FFF7, 0);

    // Reserved op: no stall, no HI/LO change
    ex_muldiv_op = 3'd7;
    ex_reg1_data = 32'h5555_AAAA;
    #1;
    check("op7_stall", {31'b0, ex_stall}, 32'd0);
    @(posedge clock); #1;
    check("op7_hi", ex_hi, m_hi);
    check("op7_lo", ex_lo, m_lo);
    ex_muldiv_op = 3'd0;

    // Downstream hold across DONE, also asserted through RUN/FIX
    issue(3'd1, 32'd5, 32'd6, 3);

    // Abandon a multiply at RUN cycle 10
    ex_muldiv_op = 3'd1;
    ex_reg1_data = 32'h1234_5678;
    ex_reg2_data = 32'h9ABC_DEF0;
    repeat (11) @(posedge clock);
    #1;
    do_reset();

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      issue(op, a, b, $urandom_range(0, 2));
    end

    repeat (4) @(negedge clock);
    check("queue_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
